// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared constants for the data-memory responder (MMIO map, modes).
// Revision: 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [5:0] CYCLE_OFS  = 6'h00;
    localparam logic [5:0] TOHOST_OFS = 6'h04;
    localparam logic [5:0] ERR_OFS    = 6'h08;

    localparam logic MODE_WORD = 1'b0;
    localparam logic MODE_BYTE = 1'b1;

    // Number of word-index bits needed to address a RAM of the given depth.
    function automatic int ram_idx_width(input int depth_words);
        return $clog2(depth_words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_mmio.sv
`default_nettype none
// ============================================================================
// Module  : dmem_mmio
// Brief   : MMIO registers: free-running CYCLE, TOHOST/halt latch, err flag.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            off,
    input  logic                  we,
    input  logic [WORD_WIDTH-1:0] wdata,
    input  logic                  err_set,
    output logic [WORD_WIDTH-1:0] rdata,
    output logic                  halt,
    output logic [WORD_WIDTH-1:0] halt_code,
    output logic                  err
);

    logic [WORD_WIDTH-1:0] cycle_q, cycle_d;
    logic                  halt_q, halt_d;
    logic [WORD_WIDTH-1:0] halt_code_q, halt_code_d;
    logic                  err_q, err_d;

    always_comb begin
        cycle_d     = cycle_q + 1'b1;
        halt_d      = halt_q;
        halt_code_d = halt_code_q;
        err_d       = err_q;

        if (we && (off == TOHOST_OFS) && !halt_q) begin
            halt_code_d = wdata;
            halt_d      = (wdata != '0);
        end

        // A new error wins over a simultaneous clear.
        if (err_set) begin
            err_d = 1'b1;
        end else if (we && (off == ERR_OFS)) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q     <= '0;
            halt_q      <= 1'b0;
            halt_code_q <= '0;
            err_q       <= 1'b0;
        end else begin
            cycle_q     <= cycle_d;
            halt_q      <= halt_d;
            halt_code_q <= halt_code_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        rdata = '0;
        case (off)
            CYCLE_OFS:  rdata = cycle_q;
            TOHOST_OFS: rdata = halt_code_q;
            ERR_OFS:    rdata = {{(WORD_WIDTH-1){1'b0}}, err_q};
            default:    rdata = '0;
        endcase
    end

    assign halt      = halt_q;
    assign halt_code = halt_code_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Brief   : D_MEM slave: word RAM with byte lanes, registered load data, MMIO.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    WORD_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WORD_WIDTH-1:0] dataIn,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic                  memMode,
    output logic [WORD_WIDTH-1:0] dataOut,
    output logic                  halt,
    output logic [WORD_WIDTH-1:0] haltCode,
    output logic                  err
);

    localparam int IDX_W = ram_idx_width(DEPTH_WORDS);

    logic [WORD_WIDTH-1:0] ram_q [DEPTH_WORDS];
    logic [WORD_WIDTH-1:0] data_out_q, data_out_d;

    logic [IDX_W-1:0]      ram_idx;
    logic [4:0]            lane_sh;
    logic                  is_mmio;
    logic                  misaligned;
    logic                  mmio_byte;
    logic                  bad_access;
    logic                  access_err;
    logic                  store_ok;
    logic                  ram_we;
    logic                  mmio_we;
    logic [WORD_WIDTH-1:0] ram_word;
    logic [7:0]            lane_byte;
    logic [WORD_WIDTH-1:0] mmio_rdata;

    assign ram_idx    = addr[IDX_W+1:2];
    assign lane_sh    = {addr[1:0], 3'b000};
    assign is_mmio    = (addr[ADDR_WIDTH-1:6] == MMIO_BASE[ADDR_WIDTH-1:6]);
    assign misaligned = (memMode == MODE_WORD) && (addr[1:0] != 2'b00);
    assign mmio_byte  = is_mmio && (memMode == MODE_BYTE);
    assign bad_access = misaligned || mmio_byte;

    // Simultaneous read+write is flagged but the store still goes through.
    assign access_err = ((memRead || memWrite) && bad_access) || (memRead && memWrite);
    assign store_ok   = memWrite && !bad_access;
    assign ram_we     = store_ok && !is_mmio;
    assign mmio_we    = store_ok && is_mmio;

    assign ram_word  = ram_q[ram_idx];
    assign lane_byte = ram_word[lane_sh +: 8];

    always_comb begin
        data_out_d = data_out_q;
        if (memRead && !memWrite) begin
            if (bad_access) begin
                data_out_d = '0;
            end else if (is_mmio) begin
                data_out_d = mmio_rdata;
            end else if (memMode == MODE_BYTE) begin
                data_out_d = {{(WORD_WIDTH-8){lane_byte[7]}}, lane_byte};
            end else begin
                data_out_d = ram_word;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
        end else begin
            data_out_q <= data_out_d;
        end
    end

    // RAM contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            if (memMode == MODE_BYTE) begin
                ram_q[ram_idx][lane_sh +: 8] <= dataIn[7:0];
            end else begin
                ram_q[ram_idx] <= dataIn;
            end
        end
    end

    dmem_mmio #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_mmio (
        .clk       (clk),
        .rst       (rst),
        .off       (addr[5:0]),
        .we        (mmio_we),
        .wdata     (dataIn),
        .err_set   (access_err),
        .rdata     (mmio_rdata),
        .halt      (halt),
        .halt_code (haltCode),
        .err       (err)
    );

    assign dataOut = data_out_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_responder
// Brief   : Directed self-checking bench for dmem_responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam logic [31:0] MB = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic [31:0] dataIn = '0;
    logic        memRead = 1'b0;
    logic        memWrite = 1'b0;
    logic        memMode = 1'b0;
    logic [31:0] dataOut;
    logic        halt;
    logic [31:0] haltCode;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_WIDTH  (32),
        .WORD_WIDTH  (32),
        .DEPTH_WORDS (1024),
        .MMIO_BASE   (MB)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .dataIn   (dataIn),
        .memRead  (memRead),
        .memWrite (memWrite),
        .memMode  (memMode),
        .dataOut  (dataOut),
        .halt     (halt),
        .haltCode (haltCode),
        .err      (err)
    );

    // One access: inputs presented, one rising edge, then observed #1 later.
    task automatic access(input logic rd, input logic wr, input logic mode,
                          input logic [31:0] a, input logic [31:0] d);
        memRead  = rd;
        memWrite = wr;
        memMode  = mode;
        addr     = a;
        dataIn   = d;
        @(posedge clk);
        #1;
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dataOut !== 32'h0) begin $display("FAIL reset_dataOut: got %h exp %h", dataOut, 32'h0); errors++; end
        checks++; if (halt !== 1'b0) begin $display("FAIL reset_halt: got %b exp 0", halt); errors++; end
        checks++; if (haltCode !== 32'h0) begin $display("FAIL reset_haltCode: got %h exp 0", haltCode); errors++; end
        checks++; if (err !== 1'b0) begin $display("FAIL reset_err: got %b exp 0", err); errors++; end
        rst = 1'b0;
    endtask

    task automatic test_word;
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
        access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        checks++; if (dataOut !== 32'hDEAD_BEEF) begin $display("FAIL word_load: got %h exp %h", dataOut, 32'hDEAD_BEEF); errors++; end
        access(1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        checks++; if (dataOut !== 32'hDEAD_BEEF) begin $display("FAIL idle_hold: got %h exp %h", dataOut, 32'hDEAD_BEEF); errors++; end
    endtask

    task automatic test_byte;
        access(1'b0, 1'b1, 1'b0, 32'h10, 32'h1122_3344);
        access(1'b0, 1'b1, 1'b1, 32'h13, 32'hAAAA_AA80);
        access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        checks++; if (dataOut !== 32'h8022_3344) begin $display("FAIL byte_store_word: got %h exp %h", dataOut, 32'h8022_3344); errors++; end
        access(1'b1, 1'b0, 1'b1, 32'h13, 32'h0);
        checks++; if (dataOut !== 32'hFFFF_FF80) begin $display("FAIL byte_load_neg: got %h exp %h", dataOut, 32'hFFFF_FF80); errors++; end
        access(1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
        checks++; if (dataOut !== 32'h0000_0044) begin $display("FAIL byte_load_l0: got %h exp %h", dataOut, 32'h44); errors++; end
        access(1'b1, 1'b0, 1'b1, 32'h11, 32'h0);
        checks++; if (dataOut !== 32'h0000_0033) begin $display("FAIL byte_load_l1: got %h exp %h", dataOut, 32'h33); errors++; end
        // 1024 words = 4 KiB, so 0x1010 aliases 0x10.
        access(1'b1, 1'b0, 1'b0, 32'h1010, 32'h0);
        checks++; if (dataOut !== 32'h8022_3344) begin $display("FAIL alias_load: got %h exp %h", dataOut, 32'h8022_3344); errors++; end
        checks++; if (err !== 1'b0) begin $display("FAIL byte_no_err: got %b exp 0", err); errors++; end
    endtask

    task automatic test_errors;
        access(1'b0, 1'b1, 1'b0, 32'h100, 32'h55AA_55AA);
        access(1'b1, 1'b0, 1'b0, 32'h102, 32'h0);
        checks++; if (dataOut !== 32'h0) begin $display("FAIL misalign_load_data: got %h exp 0", dataOut); errors++; end
        checks++; if (err !== 1'b1) begin $display("FAIL misalign_load_err: got %b exp 1", err); errors++; end
        access(1'b1, 1'b0, 1'b0, MB + 32'h8, 32'h0);
        checks++; if (dataOut !== 32'h1) begin $display("FAIL err_reg_read: got %h exp 1", dataOut); errors++; end
        access(1'b0, 1'b1, 1'b0, MB + 32'h8, 32'h0);
        checks++; if (err !== 1'b0) begin $display("FAIL err_clear: got %b exp 0", err); errors++; end
        access(1'b0, 1'b1, 1'b0, 32'h102, 32'h1234_5678);
        checks++; if (err !== 1'b1) begin $display("FAIL misalign_store_err: got %b exp 1", err); errors++; end
        access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        checks++; if (dataOut !== 32'h55AA_55AA) begin $display("FAIL misalign_store_suppressed: got %h exp %h", dataOut, 32'h55AA_55AA); errors++; end
        access(1'b0, 1'b1, 1'b0, MB + 32'h8, 32'h0);
        // Read+write together: store lands, dataOut holds, err raised.
        access(1'b1, 1'b1, 1'b0, 32'h104, 32'h0BAD_CAFE);
        checks++; if (dataOut !== 32'h55AA_55AA) begin $display("FAIL rw_hold: got %h exp %h", dataOut, 32'h55AA_55AA); errors++; end
        checks++; if (err !== 1'b1) begin $display("FAIL rw_err: got %b exp 1", err); errors++; end
        access(1'b1, 1'b0, 1'b0, 32'h104, 32'h0);
        checks++; if (dataOut !== 32'h0BAD_CAFE) begin $display("FAIL rw_store: got %h exp %h", dataOut, 32'h0BAD_CAFE); errors++; end
        // Clear and new error in the same access: err must stay set.
        access(1'b1, 1'b1, 1'b0, MB + 32'h8, 32'h0);
        checks++; if (err !== 1'b1) begin $display("FAIL clear_vs_set: got %b exp 1", err); errors++; end
        access(1'b0, 1'b1, 1'b0, MB + 32'h8, 32'h0);
        access(1'b1, 1'b0, 1'b1, MB + 32'h4, 32'h0);
        checks++; if (dataOut !== 32'h0) begin $display("FAIL mmio_byte_data: got %h exp 0", dataOut); errors++; end
        checks++; if (err !== 1'b1) begin $display("FAIL mmio_byte_err: got %b exp 1", err); errors++; end
        access(1'b0, 1'b1, 1'b0, MB + 32'h8, 32'h0);
        access(1'b1, 1'b0, 1'b0, MB + 32'hC, 32'h0);
        checks++; if (dataOut !== 32'h0) begin $display("FAIL mmio_other_read: got %h exp 0", dataOut); errors++; end
        checks++; if (err !== 1'b0) begin $display("FAIL mmio_other_noerr: got %b exp 0", err); errors++; end
    endtask

    task automatic test_tohost;
        access(1'b0, 1'b1, 1'b0, MB + 32'h4, 32'h0);
        checks++; if (halt !== 1'b0) begin $display("FAIL tohost0_halt: got %b exp 0", halt); errors++; end
        checks++; if (haltCode !== 32'h0) begin $display("FAIL tohost0_code: got %h exp 0", haltCode); errors++; end
        access(1'b0, 1'b1, 1'b0, MB + 32'h4, 32'h1);
        checks++; if (halt !== 1'b1) begin $display("FAIL tohost1_halt: got %b exp 1", halt); errors++; end
        checks++; if (haltCode !== 32'h1) begin $display("FAIL tohost1_code: got %h exp 1", haltCode); errors++; end
        access(1'b0, 1'b1, 1'b0, MB + 32'h4, 32'h5);
        checks++; if (haltCode !== 32'h1) begin $display("FAIL tohost_sticky: got %h exp 1", haltCode); errors++; end
        access(1'b1, 1'b0, 1'b0, MB + 32'h4, 32'h0);
        checks++; if (dataOut !== 32'h1) begin $display("FAIL tohost_read: got %h exp 1", dataOut); errors++; end
    endtask

    task automatic test_cycle;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        access(1'b1, 1'b0, 1'b0, MB, 32'h0);
        checks++; if (dataOut !== 32'd10) begin $display("FAIL cycle_10: got %0d exp 10", dataOut); errors++; end
        access(1'b1, 1'b0, 1'b0, MB, 32'h0);
        checks++; if (dataOut !== 32'd11) begin $display("FAIL cycle_11: got %0d exp 11", dataOut); errors++; end
        access(1'b0, 1'b1, 1'b0, MB, 32'h0);
        access(1'b1, 1'b0, 1'b0, MB, 32'h0);
        checks++; if (dataOut !== 32'd13) begin $display("FAIL cycle_ro: got %0d exp 13", dataOut); errors++; end
    endtask

    task automatic test_async_reset;
        access(1'b0, 1'b1, 1'b0, 32'h20, 32'hCAFE_F00D);
        access(1'b0, 1'b1, 1'b0, MB + 32'h4, 32'h7);
        access(1'b1, 1'b0, 1'b0, 32'h22, 32'h0);
        access(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        checks++; if (dataOut !== 32'hCAFE_F00D || halt !== 1'b1 || err !== 1'b1) begin
            $display("FAIL pre_reset_state: got %h/%b/%b exp cafef00d/1/1", dataOut, halt, err); errors++; end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (dataOut !== 32'h0) begin $display("FAIL async_dataOut: got %h exp 0", dataOut); errors++; end
        checks++; if (halt !== 1'b0 || haltCode !== 32'h0) begin $display("FAIL async_halt: got %b/%h exp 0/0", halt, haltCode); errors++; end
        checks++; if (err !== 1'b0) begin $display("FAIL async_err: got %b exp 0", err); errors++; end
        @(posedge clk);
        #1;
        rst = 1'b0;
        access(1'b1, 1'b0, 1'b0, MB, 32'h0);
        checks++; if (dataOut !== 32'h0) begin $display("FAIL async_cycle: got %h exp 0", dataOut); errors++; end
        access(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        checks++; if (dataOut !== 32'hCAFE_F00D) begin $display("FAIL ram_retained: got %h exp %h", dataOut, 32'hCAFE_F00D); errors++; end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_errors();
        test_tohost();
        test_cycle();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish exp finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
